// File: rtl/frame_rx_pkg.sv
// Shared types and default geometry for the serial frame receiver.
package frame_rx_pkg;

    localparam int unsigned DEF_ADDR_W     = 3;
    localparam int unsigned DEF_DATA_W     = 18;
    localparam int unsigned DEF_NUM_FRAMES = 8;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StWrite,
        StHold,
        StDone
    } rx_state_e;

endpackage

// File: rtl/frame_shifter.sv
// Serial-to-parallel shift register with bit counter for one frame.
// word is the frame as it stands once the bit on sd this cycle is included;
// full flags that the bit presented now is the last one of the frame.
module frame_shifter #(
    parameter int unsigned WORD_W = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    input  logic              clear,
    output logic [WORD_W-1:0] word,
    output logic              full
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_count;

    assign word = {r_word[WORD_W-2:0], sd};
    assign full = !sen && (r_count == CNT_W'(WORD_W - 1));

    // Shift MSB-first on every low-sen edge; clear restarts the bit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (!sen) begin
            r_word  <= word;
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/frame_rx.sv
// Serial frame receiver: assembles index+payload frames and writes each
// payload to a buffer at the received index, tracking sequence and length
// errors until NUM_FRAMES frames have been accepted.
module frame_rx
    import frame_rx_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned NUM_FRAMES = DEF_NUM_FRAMES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    output logic              RB_RW,
    output logic [ADDR_W-1:0] RB_A,
    output logic [DATA_W-1:0] RB_D,
    output logic              frame_ok,
    output logic              seq_err,
    output logic              len_err,
    output logic              done
);

    localparam int unsigned WORD_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W  = $clog2(NUM_FRAMES + 1);

    rx_state_e r_state, w_state_next;

    logic [WORD_W-1:0] w_word;
    logic              w_full;
    logic              w_clear;
    logic              w_capture;
    logic              w_len_set;

    logic [ADDR_W-1:0] r_rb_a;
    logic [DATA_W-1:0] r_rb_d;
    logic              r_seq_err;
    logic              r_len_err;
    logic [ADDR_W-1:0] r_exp_idx;
    logic [CNT_W-1:0]  r_frames;

    frame_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .sen   (sen),
        .sd    (sd),
        .clear (w_clear),
        .word  (w_word),
        .full  (w_full)
    );

    // Next-state decode; the shifter is held clear outside frame reception.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b1;
        w_capture    = 1'b0;
        w_len_set    = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_clear = 1'b0;
                if (!sen) begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                if (sen) begin
                    w_state_next = StIdle;
                    w_len_set    = 1'b1;
                end else begin
                    w_clear = 1'b0;
                    if (w_full) begin
                        w_state_next = StWrite;
                        w_capture    = 1'b1;
                    end
                end
            end
            StWrite: begin
                // r_frames already counts the frame being written
                if (r_frames == CNT_W'(NUM_FRAMES)) begin
                    w_state_next = StDone;
                end else if (!sen) begin
                    w_state_next = StHold;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StHold: begin
                if (sen) begin
                    w_state_next = StIdle;
                end else begin
                    w_len_set = 1'b1;
                end
            end
            StDone: begin
                w_state_next = StDone;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the completed frame and update counters and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rb_a    <= '0;
            r_rb_d    <= '0;
            r_seq_err <= 1'b0;
            r_len_err <= 1'b0;
            r_exp_idx <= '0;
            r_frames  <= '0;
        end else begin
            if (w_len_set) begin
                r_len_err <= 1'b1;
            end
            if (w_capture) begin
                r_rb_a    <= w_word[WORD_W-1 -: ADDR_W];
                r_rb_d    <= w_word[DATA_W-1:0];
                r_exp_idx <= r_exp_idx + 1'b1;
                r_frames  <= r_frames + 1'b1;
                if (w_word[WORD_W-1 -: ADDR_W] != r_exp_idx) begin
                    r_seq_err <= 1'b1;
                end
            end
        end
    end

    assign RB_RW    = (r_state != StWrite);
    assign frame_ok = (r_state == StWrite);
    assign done     = (r_state == StDone);
    assign RB_A     = r_rb_a;
    assign RB_D     = r_rb_d;
    assign seq_err  = r_seq_err;
    assign len_err  = r_len_err;

endmodule

// File: tb/tb_frame_rx.sv
// Bench for frame_rx: a transaction-level model predicts every output each
// cycle for two parameterisations; literal checks pin key moments.
module tb_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sen_in;
    logic [1:0] sd_in;

    always #5 clk = ~clk;

    logic        rw0, ok0, seq0, len0, done0;
    logic [2:0]  a0;
    logic [17:0] d0;
    logic        rw1, ok1, seq1, len1, done1;
    logic [4:0]  a1;
    logic [7:0]  d1;

    frame_rx #(.ADDR_W(3), .DATA_W(18), .NUM_FRAMES(8)) u_dut0 (
        .clk(clk), .rst(rst), .sen(sen_in[0]), .sd(sd_in[0]),
        .RB_RW(rw0), .RB_A(a0), .RB_D(d0), .frame_ok(ok0),
        .seq_err(seq0), .len_err(len0), .done(done0)
    );

    frame_rx #(.ADDR_W(5), .DATA_W(8), .NUM_FRAMES(18)) u_dut1 (
        .clk(clk), .rst(rst), .sen(sen_in[1]), .sd(sd_in[1]),
        .RB_RW(rw1), .RB_A(a1), .RB_D(d1), .frame_ok(ok1),
        .seq_err(seq1), .len_err(len1), .done(done1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int aw [2] = '{3, 5};
    int dw [2] = '{18, 8};
    int nf [2] = '{8, 18};

    // Model: expected outputs after the most recent clock edge.
    logic        m_rw   [2];
    logic        m_ok   [2];
    logic        m_seq  [2];
    logic        m_len  [2];
    logic        m_done [2];
    logic        m_pend [2];
    logic [17:0] m_a    [2];
    logic [17:0] m_d    [2];
    int          m_exp  [2];
    int          m_nwr  [2];

    task automatic check(input string name, input int d,
                         input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input logic rw, input logic [17:0] a,
                           input logic [17:0] dd, input logic ok, input logic seq,
                           input logic len, input logic dn);
        check("RB_RW", d, 18'(rw), 18'(m_rw[d]));
        check("RB_A", d, a, m_a[d]);
        check("RB_D", d, dd, m_d[d]);
        check("frame_ok", d, 18'(ok), 18'(m_ok[d]));
        check("seq_err", d, 18'(seq), 18'(m_seq[d]));
        check("len_err", d, 18'(len), 18'(m_len[d]));
        check("done", d, 18'(dn), 18'(m_done[d]));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, rw0, 18'(a0), d0, ok0, seq0, len0, done0);
        cmp_dut(1, rw1, 18'(a1), 18'(d1), ok1, seq1, len1, done1);
    end

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_rw[k]   = 1'b1;
            m_ok[k]   = 1'b0;
            m_seq[k]  = 1'b0;
            m_len[k]  = 1'b0;
            m_done[k] = 1'b0;
            m_pend[k] = 1'b0;
            m_a[k]    = '0;
            m_d[k]    = '0;
            m_exp[k]  = 0;
            m_nwr[k]  = 0;
        end
    endtask

    // One clock with the given inputs on dut d; the write pulse lasts one cycle
    // and done follows the cycle after the final write.
    task automatic cyc(input int d, input logic s, input logic b);
        sen_in[d] = s;
        sd_in[d]  = b;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_rw[k] = 1'b1;
            m_ok[k] = 1'b0;
            if (m_pend[k]) begin
                m_done[k] = 1'b1;
                m_pend[k] = 1'b0;
            end
        end
    endtask

    task automatic send_frame(input int d, input int idx, input int pay,
                              input int extra, input int gap);
        int          w;
        logic [31:0] word;
        w    = aw[d] + dw[d];
        word = (32'(idx) << dw[d]) | 32'(pay);
        for (int i = w - 1; i >= 0; i--) cyc(d, 1'b0, word[i]);
        if (!m_done[d]) begin
            m_rw[d] = 1'b0;
            m_ok[d] = 1'b1;
            m_a[d]  = 18'(idx);
            m_d[d]  = 18'(pay);
            if (idx != m_exp[d]) m_seq[d] = 1'b1;
            m_exp[d] = (m_exp[d] + 1) % (1 << aw[d]);
            m_nwr[d]++;
            if (m_nwr[d] == nf[d]) m_pend[d] = 1'b1;
        end
        for (int j = 0; j < extra; j++) begin
            cyc(d, 1'b0, 1'($urandom_range(0, 1)));
            if (j >= 1 && !m_done[d]) m_len[d] = 1'b1;
        end
        for (int g = 0; g < gap; g++) cyc(d, 1'b1, 1'b0);
    endtask

    task automatic abort_frame(input int d, input int idx, input int pay, input int nbits);
        logic [31:0] word;
        word = (32'(idx) << dw[d]) | 32'(pay);
        for (int i = 0; i < nbits; i++) cyc(d, 1'b0, word[aw[d] + dw[d] - 1 - i]);
        cyc(d, 1'b1, 1'b0);
        if (!m_done[d]) m_len[d] = 1'b1;
    endtask

    task automatic pulse_reset();
        sen_in = 2'b11;
        rst    = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] word4;
        rst    = 1'b1;
        sen_in = 2'b11;
        sd_in  = 2'b00;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rw", 0, 18'(rw0), 18'd1);
        check("reset_a", 0, 18'(a0), 18'd0);
        check("reset_done", 0, 18'(done0), 18'd0);

        // Eight clean frames, then an ignored frame once done.
        send_frame(0, 0, 'h2A5A5, 0, 0);
        check("first_write_rw", 0, 18'(rw0), 18'd0);
        check("first_write_d", 0, d0, 18'h2A5A5);
        check("first_write_ok", 0, 18'(ok0), 18'd1);
        cyc(0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) send_frame(0, i, 'h2A5A5 + i, 0, 1);
        check("eight_done", 0, 18'(done0), 18'd1);
        check("eight_last_a", 0, 18'(a0), 18'd7);
        check("eight_last_d", 0, d0, 18'h2A5AC);
        check("eight_no_err", 0, 18'({seq0, len0}), 18'd0);
        send_frame(0, 0, 'h12345, 0, 1);
        check("done_absorb_d", 0, d0, 18'h2A5AC);

        // Out-of-sequence index on frame 2.
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            send_frame(0, (i == 2) ? 5 : i, 'h2A5A5 + i, 0, 0);
            if (i == 2) check("seq_write_a", 0, 18'(a0), 18'd5);
            cyc(0, 1'b1, 1'b0);
        end
        check("seq_sticky", 0, 18'(seq0), 18'd1);
        check("seq_done", 0, 18'(done0), 18'd1);

        // Short frame aborted after 10 bits, then a good frame.
        pulse_reset();
        abort_frame(0, 0, 'h11111, 10);
        check("short_len", 0, 18'(len0), 18'd1);
        send_frame(0, 0, 'h0BEEF, 0, 1);
        check("after_short_d", 0, d0, 18'h0BEEF);

        // sen low for 23 cycles.
        pulse_reset();
        send_frame(0, 0, 'h3C3C3, 2, 1);
        check("long_len", 0, 18'(len0), 18'd1);
        check("long_d", 0, d0, 18'h3C3C3);

        // Reset at bit 15 of frame 4, then replay.
        pulse_reset();
        for (int i = 0; i < 4; i++) send_frame(0, i, 'h2A5A5 + i, 0, 1);
        word4 = (32'd4 << 18) | 32'h2A5A9;
        for (int i = 0; i < 15; i++) cyc(0, 1'b0, word4[20 - i]);
        sen_in = 2'b11;
        rst    = 1'b1;
        m_reset();
        #1;
        check("midrst_rw", 0, 18'(rw0), 18'd1);
        check("midrst_a", 0, 18'(a0), 18'd0);
        check("midrst_d", 0, d0, 18'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send_frame(0, i, 'h2A5A5 + i, 0, 1);
        check("replay_done", 0, 18'(done0), 18'd1);

        // Alternate geometry: 5-bit index, 8-bit payload, 18 frames.
        pulse_reset();
        for (int i = 0; i < 18; i++) send_frame(1, i, 'h30 + i, 0, 1);
        check("alt_done", 1, 18'(done1), 18'd1);
        check("alt_last_a", 1, 18'(a1), 18'd17);
        check("alt_last_d", 1, 18'(d1), 18'h41);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_rx.md
FRAME_RX -- requirements
Module: frame_rx

Interface
REQ-001 The module SHALL have parameter ADDR_W, 3, width of the frame index field.
REQ-002 The module SHALL have parameter DATA_W, 18, width of the frame payload field.
REQ-003 The module SHALL have parameter NUM_FRAMES, 8, number of frames to accept before done.
REQ-004 The module SHALL have port clk input 1: single clock; all sampling and state changes on its rising edge.
REQ-005 The module SHALL have port rst input 1: reset, asynchronous and active-high.
REQ-006 The module SHALL have port sen input 1: frame enable; high means idle or between frames, low means a frame bit is present on sd.
REQ-007 The module SHALL have port sd input 1: serial data, MSB first, index field then payload field.
REQ-008 The module SHALL have port RB_RW output 1: buffer write strobe, 0 = write, 1 = read/idle.
REQ-009 The module SHALL have port RB_A output ADDR_W: buffer address.
REQ-010 The module SHALL have port RB_D output DATA_W: buffer write data.
REQ-011 The module SHALL have port frame_ok output 1: one-cycle pulse per accepted frame.
REQ-012 The module SHALL have port seq_err output 1: sticky flag, received index differed from expected index.
REQ-013 The module SHALL have port len_err output 1: sticky flag, sen rose before the frame was complete, or sd bits arrived after completion.
REQ-014 The module SHALL have port done output 1: high once NUM_FRAMES frames are written; held until reset.

Function
REQ-015 The block SHALL implement states IDLE, SHIFT, WRITE, HOLD, DONE.
REQ-016 IDLE: sen=0 at an edge SHALL capture sd as bit 0 of the frame, set the bit count to 1 and enter SHIFT; sen=1 SHALL remain in IDLE.
REQ-017 SHIFT: each edge with sen=0 SHALL shift sd into the LSB and increment the bit count.
REQ-018 When the count reaches ADDR_W+DATA_W, the block SHALL enter WRITE on that edge.
REQ-019 SHIFT with sen=1 before completion SHALL discard the partial frame, set len_err and return to IDLE, with no write.
REQ-020 WRITE SHALL last exactly one cycle, with RB_RW=0, RB_A = received index and RB_D = received payload, and frame_ok=1 in the same cycle.
REQ-021 Write latency SHALL be 1 cycle: RB_RW falls in the cycle after the edge that sampled the last bit.
REQ-022 After WRITE, the block SHALL enter HOLD if sen=0 or IDLE if sen=1; it SHALL go to DONE instead if the accepted-frame count reaches NUM_FRAMES.
REQ-023 HOLD: any edge with sen=0 SHALL set len_err and ignore sd; sen=1 SHALL return to IDLE.
REQ-024 Back-to-back frames SHALL need at least one sen=1 cycle between them; no bit of the next frame is lost.
REQ-025 An expected-index counter SHALL start at 0 and increment per accepted frame, wrapping modulo 2^ADDR_W.
REQ-026 A received index differing from the expected index SHALL set seq_err, but the frame SHALL still be written at the received index.
REQ-027 DONE SHALL be absorbing: done=1, RB_RW=1, sen and sd ignored.
REQ-028 When not in WRITE, RB_RW SHALL be 1, and RB_A and RB_D SHALL hold their last values.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE, bit count 0, expected index 0, frame count 0, RB_RW=1, RB_A=0, RB_D=0, frame_ok=0, seq_err=0, len_err=0, done=0.
REQ-030 Reset asserted mid-frame or during WRITE SHALL abort without any write; after release, the first frame requires sen=1 then 0 only if sen was already low (treated as IDLE entry).

Structure
REQ-031 Package frame_rx_pkg SHALL hold the state enumeration and the default ADDR_W/DATA_W/NUM_FRAMES constants.
REQ-032 The shift register plus bit counter SHALL be a sub-module frame_shifter with inputs sen/sd/clear and outputs word/full.

Verification
REQ-033 Eight frames, index 0..7, payload 18'h2A5A5+i, each separated by one sen=1 cycle -> eight writes A=i with matching D, eight frame_ok pulses, done=1 after the eighth, and no error flags.
REQ-034 Frame 2 sent with index 3'b101 -> write at A=5, seq_err=1 sticky; remaining frames are still accepted and done=1.
REQ-035 sen rises after 10 of 21 bits -> no write, len_err=1; the next full frame (index 0) is written correctly.
REQ-036 sen held low for 23 cycles -> one write from the first 21 bits, len_err=1, and extra bits ignored.
REQ-037 rst pulsed at bit 15 of frame 4 -> all outputs at reset values, no write; the replayed sequence from index 0 completes with done=1.
REQ-038 ADDR_W=5, DATA_W=8, NUM_FRAMES=18 with 13-bit frames indexed 0..17 -> 18 correct writes and done=1.
